// File: rtl/serial_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_pkg
// Description : Shared types and helpers for the serial link word receivers:
//               parity-mode constants, receive state enum, idle-word helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_rx_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_t;

  // All-ones pattern of the requested width (1..32), right-aligned in 32 bits.
  function automatic logic [31:0] IDLE_WORD(input int width);
    IDLE_WORD = 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_holdreg.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_holdreg
// Description : One-entry VALID/READY output register for link receivers.
//               Loads a completed word when empty or being drained, drops it
//               (with a one-cycle OVERFLOW pulse) when full and not drained.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_holdreg
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] out_o,
  output logic             valid_o,
  output logic             parity_err_o,
  output logic             overflow_o
);

  localparam logic [31:0]      IDLE_FULL = IDLE_WORD(WIDTH);
  localparam logic [WIDTH-1:0] IDLE      = IDLE_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;

  // Decide between load, drop-with-overflow, drain, or hold.
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovf_d   = 1'b0;
    if (load_i) begin
      if (!valid_q || ready_i) begin
        out_d   = word_i;
        valid_d = 1'b1;
        perr_d  = perr_i;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      out_d   = IDLE;
      valid_d = 1'b0;
      perr_d  = 1'b0;
    end
  end

  // Output register; reset empties it and clears any pending overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= IDLE;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_o        = out_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign overflow_o   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_receiver
// Description : LSB-first serial-to-parallel receiver with FRAME realignment,
//               optional even/odd parity and a one-entry output register.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int PARITY = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             data_i,
  input  logic             enable_i,
  input  logic             frame_i,
  output logic [WIDTH-1:0] out_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             parity_err_o,
  output logic             overflow_o
);

  // Counter is one bit wider than an index so it can never wrap.
  localparam int CW = $clog2(WIDTH) + 1;

  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             w_complete;
  logic             w_perr;

  // Next-state logic: FRAME always restarts a word; otherwise collect bits.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    w_complete = 1'b0;
    w_perr     = 1'b0;
    if (enable_i) begin
      if (frame_i) begin
        shreg_d    = '0;
        shreg_d[0] = data_i;
        cnt_d      = CW'(1);
        par_d      = data_i;
        state_d    = DATA;
      end else begin
        case (state_q)
          HUNT: begin
            state_d = HUNT;
          end
          DATA: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt_q == CW'(i)) shreg_d[i] = data_i;
            end
            par_d = par_q ^ data_i;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              if (PARITY == PAR_NONE) begin
                w_complete = 1'b1;
                state_d    = HUNT;
                cnt_d      = '0;
              end else begin
                state_d = PAR;
              end
            end
          end
          PAR: begin
            w_complete = 1'b1;
            state_d    = HUNT;
            cnt_d      = '0;
            // par_q holds the XOR of the data bits; fold in the parity bit.
            w_perr     = (PARITY == PAR_ODD) ? ~(par_q ^ data_i) : (par_q ^ data_i);
          end
          default: begin
            state_d = HUNT;
          end
        endcase
      end
    end
  end

  // Receive state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
    end
  end

  serial_rx_holdreg #(
    .WIDTH (WIDTH)
  ) u_holdreg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (w_complete),
    .word_i       (shreg_d),
    .perr_i       (w_perr),
    .ready_i      (ready_i),
    .out_o        (out_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .overflow_o   (overflow_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_receiver
// Description : Directed and random stimulus for serial_frame_receiver
//               (16-bit no parity, 8-bit even, 8-bit odd) against a
//               bit-collection reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, a_fr, a_d, a_rdy;
  logic [15:0] a_out;
  logic        a_v, a_pe, a_ovf;
  logic        b_en, b_fr, b_d, b_rdy;
  logic [7:0]  e_out, o_out;
  logic        e_v, e_pe, e_ovf, o_v, o_pe, o_ovf;

  serial_frame_receiver #(.WIDTH(16), .PARITY(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_d), .enable_i(a_en), .frame_i(a_fr),
    .out_o(a_out), .valid_o(a_v), .ready_i(a_rdy), .parity_err_o(a_pe), .overflow_o(a_ovf));

  serial_frame_receiver #(.WIDTH(8), .PARITY(1)) u_dut_e (
    .clk_i(clk), .rst_i(rst), .data_i(b_d), .enable_i(b_en), .frame_i(b_fr),
    .out_o(e_out), .valid_o(e_v), .ready_i(b_rdy), .parity_err_o(e_pe), .overflow_o(e_ovf));

  serial_frame_receiver #(.WIDTH(8), .PARITY(2)) u_dut_o (
    .clk_i(clk), .rst_i(rst), .data_i(b_d), .enable_i(b_en), .frame_i(b_fr),
    .out_o(o_out), .valid_o(o_v), .ready_i(b_rdy), .parity_err_o(o_pe), .overflow_o(o_ovf));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bits collected since the last FRAME plus the output slot.
  typedef struct packed {
    int          n;
    bit          armed;
    logic [32:0] acc;
    bit          v;
    logic [31:0] o;
    bit          pe;
    bit          ovf;
  } mdl_t;

  mdl_t ma, me, mo;

  function automatic logic [31:0] idle(input int w);
    idle = 32'hFFFF_FFFF >> (32 - w);
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input int w, input int par,
                                      input bit rs, input bit en, input bit fr,
                                      input bit d, input bit rdy);
    mdl_t        r;
    bit          comp;
    logic [31:0] cw;
    bit          cpe;
    bit          x;
    int          total;
    r     = m;
    comp  = 1'b0;
    cw    = '0;
    cpe   = 1'b0;
    total = w + ((par != 0) ? 1 : 0);
    if (rs) begin
      r.n = 0; r.armed = 1'b0; r.acc = '0; r.v = 1'b0;
      r.o = idle(w); r.pe = 1'b0; r.ovf = 1'b0;
      return r;
    end
    if (en) begin
      if (fr) begin
        r.acc    = '0;
        r.acc[0] = d;
        r.n      = 1;
        r.armed  = 1'b1;
      end else if (r.armed) begin
        r.acc[r.n] = d;
        r.n        = r.n + 1;
        if (r.n == total) begin
          comp = 1'b1;
          cw   = r.acc[31:0] & idle(w);
          x    = 1'b0;
          for (int i = 0; i < total; i++) x = x ^ r.acc[i];
          cpe     = (par == 1) ? x : (par == 2) ? ~x : 1'b0;
          r.armed = 1'b0;
          r.n     = 0;
        end
      end
    end
    r.ovf = 1'b0;
    if (comp) begin
      if (!m.v || rdy) begin
        r.o = cw; r.v = 1'b1; r.pe = cpe;
      end else begin
        r.ovf = 1'b1;
      end
    end else if (m.v && rdy) begin
      r.o = idle(w); r.v = 1'b0; r.pe = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock: update the model with pre-edge inputs, then compare.
  task automatic step();
    ma = model_next(ma, 16, 0, rst, a_en, a_fr, a_d, a_rdy);
    me = model_next(me, 8, 1, rst, b_en, b_fr, b_d, b_rdy);
    mo = model_next(mo, 8, 2, rst, b_en, b_fr, b_d, b_rdy);
    @(posedge clk);
    #1;
    check("a_out",   32'(a_out), ma.o);
    check("a_valid", 32'(a_v),   32'(ma.v));
    check("a_perr",  32'(a_pe),  32'(ma.pe));
    check("a_ovf",   32'(a_ovf), 32'(ma.ovf));
    check("e_out",   32'(e_out), me.o);
    check("e_valid", 32'(e_v),   32'(me.v));
    check("e_perr",  32'(e_pe),  32'(me.pe));
    check("e_ovf",   32'(e_ovf), 32'(me.ovf));
    check("o_out",   32'(o_out), mo.o);
    check("o_valid", 32'(o_v),   32'(mo.v));
    check("o_perr",  32'(o_pe),  32'(mo.pe));
    check("o_ovf",   32'(o_ovf), 32'(mo.ovf));
  endtask

  task automatic drive(input bit grp, input bit en, input bit fr, input bit d);
    if (!grp) begin
      a_en = en; a_fr = fr; a_d = d; b_en = 1'b0;
    end else begin
      b_en = en; b_fr = fr; b_d = d; a_en = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int k);
    a_en = 1'b0;
    b_en = 1'b0;
    repeat (k) step();
  endtask

  // Send nb bits LSB-first; FRAME on the first bit when fr is set.
  task automatic send(input bit grp, input logic [32:0] bits, input int nb,
                      input bit gap, input bit fr);
    for (int i = 0; i < nb; i++) begin
      drive(grp, 1'b1, fr && (i == 0), bits[i]);
      step();
      if (gap) begin
        drive(grp, 1'b0, 1'($urandom), 1'($urandom));
        step();
      end
    end
    drive(grp, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a_en = 1'b0; a_fr = 1'b0; a_d = 1'b0; a_rdy = 1'b1;
    b_en = 1'b0; b_fr = 1'b0; b_d = 1'b0; b_rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Plain 16-bit word, consumer always ready.
    send(1'b0, 33'hA5C3, 16, 1'b0, 1'b1);
    idle_cycles(3);

    // 8-bit parity words: good then bad parity bit (for even mode).
    send(1'b1, 33'h05A, 9, 1'b0, 1'b1);
    idle_cycles(2);
    send(1'b1, 33'h15A, 9, 1'b0, 1'b1);
    idle_cycles(2);

    // Consumer stalled: second word is dropped with an overflow pulse.
    a_rdy = 1'b0;
    send(1'b0, 33'h1234, 16, 1'b0, 1'b1);
    send(1'b0, 33'hBEEF, 16, 1'b0, 1'b1);
    idle_cycles(2);
    a_rdy = 1'b1;
    idle_cycles(2);

    // Aborted fragment followed by a full word.
    send(1'b0, 33'h006D, 7, 1'b0, 1'b1);
    send(1'b0, 33'h00FF, 16, 1'b0, 1'b1);
    idle_cycles(2);

    // Gapped enable.
    send(1'b0, 33'hCAFE, 16, 1'b1, 1'b1);
    idle_cycles(2);

    // Reset mid-word, then bits without FRAME must be ignored.
    send(1'b0, 33'h3C3C, 10, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(1'b0, 33'h1111, 16, 1'b0, 1'b0);
    idle_cycles(2);

    // Reset while a word is held.
    a_rdy = 1'b0;
    send(1'b0, 33'h2222, 16, 1'b0, 1'b1);
    idle_cycles(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_rdy = 1'b1;
    idle_cycles(2);

    // Random traffic on both links.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 499) == 0);
      a_en  = ($urandom_range(0, 3) != 0);
      a_fr  = ($urandom_range(0, 19) == 0);
      a_d   = 1'($urandom);
      a_rdy = ($urandom_range(0, 2) != 0);
      b_en  = ($urandom_range(0, 3) != 0);
      b_fr  = ($urandom_range(0, 11) == 0);
      b_d   = 1'($urandom);
      b_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Parametrised serial-to-parallel receiver: the next-generation word receiver for the inter-board serial link. Shifts in LSB-first bits on enabled clock cycles and realigns to an explicit FRAME marker. Supports an optional parity bit and presents completed words through a one-entry VALID/READY output register. Sits between the link input pins and the word consumer (decoder/FIFO); when no word is held, the output carries the all-ones idle pattern the consumers already treat as "no data".

## Interface
- WIDTH, 16, data bits per word (2..32)
- PARITY, 0, 0 = none, 1 = even, 2 = odd; when nonzero one parity bit follows the data bits
- CLOCK  input  1  sole clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- DATA  input  1  serial data bit, sampled on CLOCK rising edge when ENABLE=1
- ENABLE  input  1  bit strobe; cycles with ENABLE=0 leave all receive state unchanged
- FRAME  input  1  start-of-word marker; meaningful only when ENABLE=1
- OUT  output  WIDTH  held word while VALID=1, else all ones
- VALID  output  1  OUT holds an undelivered word
- READY  input  1  consumer accepts word; transfer when VALID&&READY at a rising edge
- PARITY_ERR  output  1  parity check failed for the held word; meaningful only while VALID=1
- OVERFLOW  output  1  one-cycle pulse: a completed word was dropped

## Operation
- Reset values: state HUNT, bit counter 0, shift register 0, OUT all ones, VALID 0, PARITY_ERR 0, OVERFLOW 0.
- States: HUNT (waiting for frame), DATA (collecting data bits), PAR (awaiting parity bit; only when PARITY≠0).
- An enabled cycle is one with ENABLE=1. All transitions below apply only on enabled cycles.
- FRAME=1 on any enabled cycle, in any state: discard the partial word; DATA is stored as bit 0; counter set to 1; go to DATA. With WIDTH=1 this bit completes the data phase immediately, per the rules below.
- HUNT with FRAME=0: the bit is ignored.
- DATA with FRAME=0: store DATA at the counter index; increment the counter.
  - When bit WIDTH-1 is stored and PARITY=0: the word completes and the state returns to HUNT.
  - When bit WIDTH-1 is stored and PARITY≠0: go to PAR.
- PAR with FRAME=0: the received bit is the parity bit and the word completes; return to HUNT.
  - Even mode: error when XOR(data bits, parity bit) = 1.
  - Odd mode: error when that XOR = 0.
- Back-to-back words each need their own FRAME; there is no implicit rearm.
- Word completion, checked at the completing edge:
  - If VALID=0, or VALID=1 with READY=1: load OUT, set VALID=1, set PARITY_ERR per the check (0 when PARITY=0).
  - If VALID=1 with READY=0: drop the new word; held OUT, VALID and PARITY_ERR are unchanged; OVERFLOW=1 for the next cycle only.
- Transfer (VALID&&READY) without a completion in the same cycle: VALID→0, OUT→all ones, PARITY_ERR→0.
- A word with a parity error is still delivered, flagged; the consumer decides.
- The counter is $clog2(WIDTH)+1 bits wide and never wraps. Only FRAME or completion resets it.

## Timing
- Latency: VALID and OUT are updated at the same edge that samples the last bit (data bit, or parity bit when enabled). They are visible in the following cycle. There is no combinational path from DATA, FRAME or READY to any output.
- All outputs are registered.
- OVERFLOW asserts for exactly one cycle after the dropping edge.
- RESET has priority over everything, including mid-word: the partial word and any held word are lost; no OVERFLOW is generated.
- FRAME on the same enabled cycle as the would-be final bit: FRAME wins. No completion occurs, and that bit becomes bit 0 of the new word.
- Throughput: one word per WIDTH (+1 with parity) enabled cycles, plus the FRAME bit, which is itself data bit 0.

## Structure
- Package serial_rx_pkg:
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - state enum rx_state_t {HUNT, DATA, PAR}
  - IDLE_WORD function returning all ones of a given width
- Sub-module serial_rx_holdreg: the one-entry OUT/VALID/PARITY_ERR register with load/transfer/overflow logic. It is parametrised by WIDTH and is reusable by future link receivers.
- The top level contains the FSM, counter, shift register and parity accumulator.

## Test plan
- WIDTH=16, PARITY=0, READY=1: FRAME with bit 0, then 15 more bits, word 0xA5C3 LSB-first → VALID for 1 cycle after the last bit, OUT=0xA5C3; then OUT=0xFFFF, VALID=0.
- WIDTH=8, PARITY=1: 0x5A plus parity bit 0 → OUT=0x5A, PARITY_ERR=0. Repeat with parity bit 1 → PARITY_ERR=1, word still delivered.
- WIDTH=16, READY=0: two complete words 0x1234 then 0xBEEF → OUT stays 0x1234, OVERFLOW pulses once after 0xBEEF's last bit. Then READY=1 → VALID drops, OUT=0xFFFF.
- FRAME reasserted after 7 bits of a word, then a full 0x00FF word → only 0x00FF is delivered; the aborted fragment never appears.
- ENABLE toggled 0/1 every other cycle during 0xCAFE → same result as continuous ENABLE, with latency measured in enabled bits.
- RESET asserted after 10 bits of a word, and again while VALID=1 → all outputs return to reset values next cycle. Subsequent bits without FRAME are ignored.
